// File: rtl/rv32_pkg.sv
// Shared RV32I definitions: opcodes, funct3 codes, instruction field
// positions and the execute/write-back state encoding.
package rv32_pkg;

   localparam int XLEN = 32;

   // Major opcodes (instr[6:0])
   localparam logic [6:0] OP_ALUREG = 7'b0110011;
   localparam logic [6:0] OP_ALUIMM = 7'b0010011;
   localparam logic [6:0] OP_STORE  = 7'b0100011;
   localparam logic [6:0] OP_BRANCH = 7'b1100011;
   localparam logic [6:0] OP_LOAD   = 7'b0000011;
   localparam logic [6:0] OP_JAL    = 7'b1101111;
   localparam logic [6:0] OP_SYSTEM = 7'b1110011;

   // ALU funct3 codes (instr[14:12])
   localparam logic [2:0] F3_ADD  = 3'b000;
   localparam logic [2:0] F3_SLL  = 3'b001;
   localparam logic [2:0] F3_SLT  = 3'b010;
   localparam logic [2:0] F3_SLTU = 3'b011;
   localparam logic [2:0] F3_XOR  = 3'b100;
   localparam logic [2:0] F3_SR   = 3'b101;
   localparam logic [2:0] F3_OR   = 3'b110;
   localparam logic [2:0] F3_AND  = 3'b111;

   // Instruction field positions
   localparam int OPC_MSB = 6;
   localparam int OPC_LSB = 0;
   localparam int RD_MSB  = 11;
   localparam int RD_LSB  = 7;
   localparam int F3_MSB  = 14;
   localparam int F3_LSB  = 12;
   localparam int RS1_MSB = 19;
   localparam int RS1_LSB = 15;
   localparam int RS2_MSB = 24;
   localparam int RS2_LSB = 20;
   localparam int IMM_MSB = 31;
   localparam int IMM_LSB = 20;
   localparam int ALT_BIT = 30;   // SUB / SRA selector

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_EXEC  = 2'd1,
      ST_SHIFT = 2'd2,
      ST_WB    = 2'd3
   } state_t;

endpackage

// File: rtl/serial_shifter.sv
// Bit-serial barrel-shift replacement: one bit position per clock.
// The first step is taken on the load edge itself, so a shift by n
// stays busy for n-1 cycles after load.
module serial_shifter
   import rv32_pkg::*;
(
   input  logic            clk,
   input  logic            resetn,
   input  logic            load,
   input  logic [XLEN-1:0] value,
   input  logic [4:0]      shamt,
   input  logic            dir,     // 0 = left, 1 = right
   input  logic            arith,   // right shifts replicate the sign bit
   output logic [XLEN-1:0] result,
   output logic            busy
);

   logic [XLEN-1:0] r_val;
   logic [4:0]      r_cnt;
   logic            r_dir;
   logic            r_arith;

   function automatic logic [XLEN-1:0] f_step(input logic [XLEN-1:0] v,
                                              input logic d,
                                              input logic a);
      if (!d)
         return {v[XLEN-2:0], 1'b0};
      return {a & v[XLEN-1], v[XLEN-1:1]};
   endfunction

   // Load the operand (first step applied) or advance one bit per cycle.
   always_ff @(posedge clk) begin
      if (!resetn) begin
         r_val   <= '0;
         r_cnt   <= '0;
         r_dir   <= 1'b0;
         r_arith <= 1'b0;
      end else if (load) begin
         r_dir   <= dir;
         r_arith <= arith;
         if (shamt == 5'd0) begin
            r_val <= value;
            r_cnt <= 5'd0;
         end else begin
            r_val <= f_step(value, dir, arith);
            r_cnt <= shamt - 5'd1;
         end
      end else if (r_cnt != 5'd0) begin
         r_val <= f_step(r_val, r_dir, r_arith);
         r_cnt <= r_cnt - 5'd1;
      end
   end

   assign result = r_val;
   assign busy   = (r_cnt != 5'd0);

endmodule

// File: rtl/alu_writeback.sv
// RV32I execute/write-back stage for ALU-register and ALU-immediate
// instructions. Latches the instruction and operands on start, computes
// in EXEC (shifts continue bit-serially in SHIFT) and presents the
// register-bank write with a one-cycle done pulse in WB.
module alu_writeback
   import rv32_pkg::*;
(
   input  logic            clk,
   input  logic            resetn,
   input  logic            start,
   input  logic [XLEN-1:0] instr,
   input  logic [XLEN-1:0] rs1,
   input  logic [XLEN-1:0] rs2,
   output logic            busy,
   output logic            done,
   output logic            illegal,
   output logic            wb_en,
   output logic [4:0]      wb_rd,
   output logic [XLEN-1:0] wb_data
);

   state_t          r_state;
   logic [XLEN-1:0] r_instr;
   logic [XLEN-1:0] r_rs1;
   logic [XLEN-1:0] r_rs2;
   logic            r_busy;
   logic            r_done;
   logic            r_illegal;
   logic            r_wb_en;
   logic [4:0]      r_wb_rd;
   logic [XLEN-1:0] r_wb_data;

   logic [6:0]      w_opcode;
   logic [2:0]      w_f3;
   logic [4:0]      w_rd;
   logic            w_alt;
   logic            w_is_reg;
   logic            w_legal;
   logic [XLEN-1:0] w_op2;
   logic [4:0]      w_shamt;
   logic            w_is_shift;
   logic [XLEN-1:0] w_alu;
   logic            w_sh_load;
   logic            w_sh_busy;
   logic [XLEN-1:0] w_sh_result;
   logic            w_finish;
   logic [XLEN-1:0] w_fin_data;
   logic            w_unused_rs1;

   // Decode of the latched instruction
   assign w_opcode   = r_instr[OPC_MSB:OPC_LSB];
   assign w_f3       = r_instr[F3_MSB:F3_LSB];
   assign w_rd       = r_instr[RD_MSB:RD_LSB];
   assign w_alt      = r_instr[ALT_BIT];
   assign w_is_reg   = (w_opcode == OP_ALUREG);
   assign w_legal    = w_is_reg || (w_opcode == OP_ALUIMM);
   assign w_op2      = w_is_reg ? r_rs2
                                : {{(XLEN-12){r_instr[IMM_MSB]}}, r_instr[IMM_MSB:IMM_LSB]};
   assign w_shamt    = w_op2[4:0];
   assign w_is_shift = (w_f3 == F3_SLL) || (w_f3 == F3_SR);

   // The operand was read by the sequencer; the register index itself is not needed here.
   assign w_unused_rs1 = ^r_instr[RS1_MSB:RS1_LSB];

   // Single-cycle ALU result; shifts by zero pass rs1 through unchanged.
   always_comb begin
      w_alu = '0;
      case (w_f3)
         F3_ADD:  w_alu = (w_is_reg && w_alt) ? (r_rs1 - w_op2) : (r_rs1 + w_op2);
         F3_SLL:  w_alu = r_rs1;
         F3_SLT:  w_alu = {{(XLEN-1){1'b0}}, ($signed(r_rs1) < $signed(w_op2))};
         F3_SLTU: w_alu = {{(XLEN-1){1'b0}}, (r_rs1 < w_op2)};
         F3_XOR:  w_alu = r_rs1 ^ w_op2;
         F3_SR:   w_alu = r_rs1;
         F3_OR:   w_alu = r_rs1 | w_op2;
         F3_AND:  w_alu = r_rs1 & w_op2;
         default: w_alu = '0;
      endcase
   end

   assign w_sh_load  = (r_state == ST_EXEC) && w_legal && w_is_shift && (w_shamt != 5'd0);
   assign w_finish   = ((r_state == ST_EXEC) && !w_sh_load) ||
                       ((r_state == ST_SHIFT) && !w_sh_busy);
   assign w_fin_data = !w_legal                ? '0 :
                       (r_state == ST_SHIFT)   ? w_sh_result : w_alu;

   serial_shifter u_shifter (
      .clk    (clk),
      .resetn (resetn),
      .load   (w_sh_load),
      .value  (r_rs1),
      .shamt  (w_shamt),
      .dir    (w_f3 == F3_SR),
      .arith  (w_alt),
      .result (w_sh_result),
      .busy   (w_sh_busy)
   );

   // Control FSM with registered write-back outputs.
   always_ff @(posedge clk) begin
      if (!resetn) begin
         r_state   <= ST_IDLE;
         r_instr   <= '0;
         r_rs1     <= '0;
         r_rs2     <= '0;
         r_busy    <= 1'b0;
         r_done    <= 1'b0;
         r_illegal <= 1'b0;
         r_wb_en   <= 1'b0;
         r_wb_rd   <= '0;
         r_wb_data <= '0;
      end else begin
         r_done    <= 1'b0;
         r_illegal <= 1'b0;
         r_wb_en   <= 1'b0;
         case (r_state)
            ST_IDLE: begin
               if (start) begin
                  r_instr <= instr;
                  r_rs1   <= rs1;
                  r_rs2   <= rs2;
                  r_busy  <= 1'b1;
                  r_state <= ST_EXEC;
               end
            end
            ST_EXEC:  r_state <= w_sh_load ? ST_SHIFT : ST_WB;
            ST_SHIFT: if (!w_sh_busy) r_state <= ST_WB;
            ST_WB: begin
               r_busy  <= 1'b0;
               r_state <= ST_IDLE;
            end
            default:  r_state <= ST_IDLE;
         endcase
         if (w_finish) begin
            r_done    <= 1'b1;
            r_illegal <= !w_legal;
            r_wb_en   <= w_legal && (w_rd != 5'd0);
            r_wb_rd   <= w_rd;
            r_wb_data <= w_fin_data;
         end
      end
   end

   assign busy    = r_busy;
   assign done    = r_done;
   assign illegal = r_illegal;
   assign wb_en   = r_wb_en;
   assign wb_rd   = r_wb_rd;
   assign wb_data = r_wb_data;

endmodule

// File: tb/tb_alu_writeback.sv
// Self-checking bench for alu_writeback: directed cases plus random
// ALU instructions compared against a plain-arithmetic reference model.
module tb_alu_writeback;

   logic        clk = 1'b0;
   logic        resetn;
   logic        start;
   logic [31:0] instr;
   logic [31:0] rs1;
   logic [31:0] rs2;
   logic        busy;
   logic        done;
   logic        illegal;
   logic        wb_en;
   logic [4:0]  wb_rd;
   logic [31:0] wb_data;

   int n_checks = 0;
   int n_err    = 0;

   alu_writeback dut (
      .clk     (clk),
      .resetn  (resetn),
      .start   (start),
      .instr   (instr),
      .rs1     (rs1),
      .rs2     (rs2),
      .busy    (busy),
      .done    (done),
      .illegal (illegal),
      .wb_en   (wb_en),
      .wb_rd   (wb_rd),
      .wb_data (wb_data)
   );

   always #5 clk = ~clk;

   initial begin
      #400000;
      $display("FAIL watchdog: simulation did not finish, observed=timeout expected=finish");
      $fatal(1, "watchdog");
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   // Reference: result, illegal flag and done latency (edges from acceptance).
   function automatic void model(input logic [31:0] i, input logic [31:0] a,
                                 input logic [31:0] b, output logic [31:0] d,
                                 output logic ill, output int lat);
      logic [31:0] op2;
      int          sh;
      logic        isreg;
      logic        isimm;
      isreg = (i[6:0] == 7'b0110011);
      isimm = (i[6:0] == 7'b0010011);
      d   = 32'd0;
      ill = 1'b0;
      lat = 2;
      if (!isreg && !isimm) begin
         ill = 1'b1;
         return;
      end
      op2 = isreg ? b : {{20{i[31]}}, i[31:20]};
      sh  = int'(op2 % 32);
      case (i[14:12])
         3'd0: d = (isreg && i[30]) ? a - op2 : a + op2;
         3'd1: begin d = a << sh; lat = lat + sh; end
         3'd2: d = ($signed(a) < $signed(op2)) ? 32'd1 : 32'd0;
         3'd3: d = (a < op2) ? 32'd1 : 32'd0;
         3'd4: d = a ^ op2;
         3'd5: begin
            d = i[30] ? 32'($signed(a) >>> sh) : (a >> sh);
            lat = lat + sh;
         end
         3'd6: d = a | op2;
         default: d = a & op2;
      endcase
   endfunction

   // Present a start for one edge, then scramble the inputs to prove latching.
   task automatic issue(input logic [31:0] i, input logic [31:0] a, input logic [31:0] b);
      instr = i; rs1 = a; rs2 = b; start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0; instr = $urandom; rs1 = $urandom; rs2 = $urandom;
   endtask

   // Issue one instruction and check timing and write-back. If poke>0 a
   // competing start is driven during that cycle after acceptance.
   task automatic run(input string tag, input logic [31:0] i, input logic [31:0] a,
                      input logic [31:0] b, input int poke);
      logic [31:0] ed;
      logic        eill;
      int          elat;
      int          cyc;
      model(i, a, b, ed, eill, elat);
      issue(i, a, b);
      chk({tag, ".busy1"}, 32'(busy), 32'd1);
      cyc = 1;
      while (!done && cyc < 64) begin
         if (cyc == poke) begin
            start = 1'b1; instr = 32'h002081B3; rs1 = $urandom; rs2 = $urandom;
         end
         @(posedge clk); #1;
         start = 1'b0;
         cyc++;
      end
      chk({tag, ".lat"},     32'(cyc),     32'(elat));
      chk({tag, ".done"},    32'(done),    32'd1);
      chk({tag, ".illegal"}, 32'(illegal), 32'(eill));
      chk({tag, ".wb_en"},   32'(wb_en),   32'(!eill && (i[11:7] != 5'd0)));
      chk({tag, ".wb_rd"},   32'(wb_rd),   32'(i[11:7]));
      chk({tag, ".wb_data"}, wb_data,      ed);
      @(posedge clk); #1;
      chk({tag, ".done0"},   32'(done),    32'd0);
      chk({tag, ".busy0"},   32'(busy),    32'd0);
      chk({tag, ".wb_en0"},  32'(wb_en),   32'd0);
      chk({tag, ".held"},    wb_data,      ed);
   endtask

   task automatic chk_reset_outputs(input string tag);
      chk({tag, ".busy"},    32'(busy),    32'd0);
      chk({tag, ".done"},    32'(done),    32'd0);
      chk({tag, ".illegal"}, 32'(illegal), 32'd0);
      chk({tag, ".wb_en"},   32'(wb_en),   32'd0);
      chk({tag, ".wb_rd"},   32'(wb_rd),   32'd0);
      chk({tag, ".wb_data"}, wb_data,      32'd0);
   endtask

   initial begin
      logic [31:0] ri;
      logic [31:0] ra;
      logic [31:0] rb;
      int          sel;
      int          seen;

      resetn = 1'b0; start = 1'b0; instr = '0; rs1 = '0; rs2 = '0;
      repeat (2) @(posedge clk);
      #1;
      chk_reset_outputs("reset");
      resetn = 1'b1;

      // Directed cases
      run("add",  32'h002081B3, 32'd5, 32'd7, 0);
      chk("add.val", wb_data, 32'h0000000C);
      run("sub",  32'h402081B3, 32'd5, 32'd7, 0);
      chk("sub.val", wb_data, 32'hFFFFFFFE);
      run("addi", 32'hFFF00093, 32'd0, 32'h12345678, 0);
      chk("addi.val", wb_data, 32'hFFFFFFFF);
      run("srai", 32'h40435293, 32'h80000000, 32'd0, 0);
      chk("srai.val", wb_data, 32'hF8000000);
      run("srli", 32'h00435293, 32'h80000000, 32'd0, 0);
      chk("srli.val", wb_data, 32'h08000000);
      run("slt",  32'h0020A1B3, 32'hFFFFFFFF, 32'd1, 0);
      chk("slt.val", wb_data, 32'd1);
      run("sltu", 32'h0020B1B3, 32'hFFFFFFFF, 32'd1, 0);
      chk("sltu.val", wb_data, 32'd0);
      run("sll31", 32'h002091B3, 32'h00000003, 32'h0000003F, 0);
      run("sra31", 32'h4020D1B3, 32'h80000000, 32'd31, 0);
      run("sll0", 32'h00009193, 32'hA5A5A5A5, 32'd0, 0);
      run("addx0", 32'h00208033, 32'd5, 32'd7, 0);
      run("ecall", 32'h00000073, 32'd5, 32'd7, 0);
      chk("ecall.val", wb_data, 32'd0);
      run("srai_poke", 32'h40435293, 32'h80000000, 32'd0, 3);
      chk("srai_poke.val", wb_data, 32'hF8000000);
      run("add_poke_wb", 32'h002081B3, 32'd100, 32'd23, 2);

      // Reset in the middle of an SLLI by 20
      issue(32'h01409393, 32'h00000001, 32'd0);
      @(posedge clk); #1;
      @(posedge clk); #1;
      resetn = 1'b0;
      @(posedge clk); #1;
      chk_reset_outputs("midreset");
      resetn = 1'b1;
      seen = 0;
      repeat (30) begin
         @(posedge clk); #1;
         if (done || wb_en || busy) seen++;
      end
      chk("midreset.quiet", 32'(seen), 32'd0);
      run("after_reset", 32'h002081B3, 32'd5, 32'd7, 0);

      // Start coincident with reset is dropped
      resetn = 1'b0;
      issue(32'h002081B3, 32'd1, 32'd2);
      resetn = 1'b1;
      seen = 0;
      repeat (5) begin
         @(posedge clk); #1;
         if (done || busy) seen++;
      end
      chk("rst_start.dropped", 32'(seen), 32'd0);

      // Random ALU instructions (occasional illegal opcodes)
      for (int k = 0; k < 60; k++) begin
         sel = int'($urandom_range(0, 9));
         ri  = $urandom;
         ra  = $urandom;
         rb  = (sel % 3 == 0) ? 32'($urandom_range(0, 40)) : $urandom;
         if (sel < 5) begin
            ri[6:0]   = 7'b0110011;
            ri[31]    = 1'b0;
            ri[29:25] = 5'd0;
         end else if (sel < 9) begin
            ri[6:0] = 7'b0010011;
         end
         run($sformatf("rnd%0d", k), ri, ra, rb, (k % 7 == 0) ? 2 : 0);
      end

      $display("Result: errors=%0d of %0d checks", n_err, n_checks);
      $finish;
   end

endmodule

// File: doc/alu_writeback.md
# alu_writeback

Execute/write-back stage of the multi-cycle RV32I core. The fetch/register-read sequencer presents a fetched instruction and its two register-bank operands with a `start` pulse. This block decodes ALU-register and ALU-immediate instructions, computes the result, and drives the register-bank write port (`wb_en`, `wb_rd`, `wb_data`) with a one-cycle `done` pulse that releases the sequencer to fetch the next instruction. Shifts are bit-serial to keep LUT count low.

## Interface
- XLEN, 32: datapath width; only 32 is supported, and shift amount is 5 bits.

- clk  in  1  core clock (post-Clockworks)
- resetn  in  1  synchronous, active-low reset
- start  in  1  request pulse; sampled only while busy=0
- instr  in  32  instruction word, sampled with start
- rs1  in  32  register-bank operand for instr[19:15], sampled with start
- rs2  in  32  register-bank operand for instr[24:20], sampled with start
- busy  out  1  high from the cycle after an accepted start through the done cycle
- done  out  1  one-cycle completion pulse
- illegal  out  1  high with done when the opcode is not ALU-reg or ALU-imm
- wb_en  out  1  register-bank write enable; one cycle, coincident with done
- wb_rd  out  5  destination register (instr[11:7])
- wb_data  out  32  result; held from done until the next accepted start

## Operation
- States:
  - IDLE: start=1 latches instr, rs1 and rs2, then goes to EXEC.
  - EXEC: computes the result. Non-shift ops and shifts with shamt=0 go to WB. Other shifts load the shifter and go to SHIFT.
  - SHIFT: one bit per cycle, counter = shamt; moves to WB when the counter reaches 0.
  - WB: asserts done; returns to IDLE.
- Decode:
  - Opcode 0110011: op2 = rs2.
  - Opcode 0010011: op2 = sign-extended instr[31:20].
  - Any other opcode is illegal.
- funct3 map:
  - 000: ADD; SUB only when R-type and instr[30]=1 (ADDI ignores instr[30]).
  - 001: SLL.
  - 010: SLT (signed).
  - 011: SLTU.
  - 100: XOR.
  - 101: SRL, or SRA when instr[30]=1 (both types).
  - 110: OR.
  - 111: AND.
- shamt = op2[4:0]. SRA fills with the sign bit on every serial step.
- Arithmetic is 32-bit modulo with no overflow flag. SLT/SLTU produce 0 or 1, zero-extended.
- wb_en = done & ~illegal & (wb_rd != 0).
- On an illegal instruction, wb_data = 0.
- An instruction with rd=0 still completes and computes wb_data, with wb_en=0.
- start while busy=1 (EXEC/SHIFT/WB) is ignored and not queued.

## Timing
- Reset values: busy=0, done=0, illegal=0, wb_en=0, wb_rd=0, wb_data=0; state=IDLE.
- Accepted start at edge t: EXEC is the cycle after edge t, and done=1 in cycle t+2 (non-shift or shamt=0).
- Shift with shamt=n>0: done in cycle t+2+n. The worst case, n=31, gives t+33.
- busy=1 from cycle t+1 through the done cycle inclusive. The earliest next start is accepted in the cycle after done.
- Reset asserted mid-operation: IDLE at the next edge, no done or wb_en pulse, outputs at reset values.
- Start coincident with resetn=0 is dropped.

## Structure
- Shared package `rv32_pkg`:
  - Opcode constants (OP_ALUREG=0110011, OP_ALUIMM=0010011, OP_STORE, OP_BRANCH, OP_LOAD, OP_JAL, OP_SYSTEM).
  - funct3 constants.
  - State encoding (IDLE/EXEC/SHIFT/WB).
  - The rd/rs1/rs2 field slices.
- One sub-module, `serial_shifter`:
  - Inputs: load, value, shamt, dir, arith.
  - Outputs: result, busy.
  - The same counter is reused later for the load/store byte-lane logic.

## Test plan
- ADD x3,x1,x2 (0x002081B3), rs1=5, rs2=7, start at t → done at t+2, wb_en=1, wb_rd=3, wb_data=0x0000000C.
- SUB (0x402081B3), rs1=5, rs2=7 → wb_data=0xFFFFFFFE. ADDI x1,x0,-1 (0xFFF00093), rs1=0 → wb_data=0xFFFFFFFF, wb_rd=1.
- SRAI x5,x6,4 (0x40435293), rs1=0x80000000 → done at t+6, wb_data=0xF8000000. Same with SRLI (0x00435293) → 0x08000000. SLT vs SLTU with rs1=0xFFFFFFFF, rs2=1 → 1 and 0.
- ADD x0 (0x00208033) → done=1, wb_en=0. ECALL (0x00000073) → done=1, illegal=1, wb_en=0, wb_data=0.
- start pulsed during SHIFT with a different instr → ignored; the original result completes unchanged.
- resetn=0 at cycle t+3 of an SLLI by 20 → no done pulse, all outputs 0. A following ADD completes normally.
